// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        SIGN,
        DONE
    } md_state_t;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_sequencer_div_iter.sv
// One combinational radix-2 restoring division step over a packed
// {partial remainder, quotient} register.
module div_iter (
    input  logic [63:0] rq_in,
    input  logic [31:0] divisor,
    output logic [63:0] rq_out
);

    logic [32:0] top;
    logic [32:0] diff;
    logic        fits;

    // The shifted remainder can need 33 bits, so compare at that width.
    always_comb begin
        top    = rq_in[63:31];
        diff   = top - {1'b0, divisor};
        fits   = (top >= {1'b0, divisor});
        rq_out = fits ? {diff[31:0], rq_in[30:0], 1'b1}
                      : {top[31:0],  rq_in[30:0], 1'b0};
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: stalls the pipeline while a
// MULT/MULTU/DIV/DIVU runs, then pulses result_valid with {hi, lo}.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

    md_state_t   state;
    logic [4:0]  cnt;
    md_op_t      op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] rq;
    logic [63:0] rq_next;
    logic [31:0] dvsr;
    logic [63:0] mul_pipe [MUL_CYCLES];

    logic        accept;
    logic        signed_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    assign accept       = (state == IDLE) && op_valid && !flush;
    assign stall_req    = !rst && (accept || state == MUL || state == DIV || state == SIGN);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

    // Operand preparation at accept: sign-extended product, divider magnitudes.
    always_comb begin
        signed_div = (md_op_t'(op_type) == MD_DIV);
        mag_a      = (signed_div && src_a[31]) ? -src_a : src_a;
        mag_b      = (signed_div && src_b[31]) ? -src_b : src_b;
        ext_a      = (md_op_t'(op_type) == MD_MULT) ? {{32{src_a[31]}}, src_a} : {32'b0, src_a};
        ext_b      = (md_op_t'(op_type) == MD_MULT) ? {{32{src_b[31]}}, src_b} : {32'b0, src_b};
        product    = ext_a * ext_b;
    end

    // Divide-by-zero bypasses the sign fix and reports the raw dividend.
    always_comb begin
        fix_hi = rq[63:32];
        fix_lo = rq[31:0];
        if (b_reg == 32'b0) begin
            fix_hi = a_reg;
            fix_lo = 32'hFFFF_FFFF;
        end else if (op_reg == MD_DIV) begin
            if (a_reg[31] ^ b_reg[31]) fix_lo = -rq[31:0];
            if (a_reg[31])             fix_hi = -rq[63:32];
        end
    end

    div_iter u_div_iter (
        .rq_in   (rq),
        .divisor (dvsr),
        .rq_out  (rq_next)
    );

    always_ff @(posedge clk) begin
        if (accept) mul_pipe[0] <= product;
        for (int i = 1; i < MUL_CYCLES; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_reg <= MD_MULT;
            a_reg  <= '0;
            b_reg  <= '0;
            rq     <= '0;
            dvsr   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_reg <= md_op_t'(op_type);
                        a_reg  <= src_a;
                        b_reg  <= src_b;
                        rq     <= {32'b0, mag_a};
                        dvsr   <= mag_b;
                        cnt    <= '0;
                        state  <= op_type[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (cnt == MUL_LAST) begin
                        {hi, lo} <= mul_pipe[MUL_CYCLES-1];
                        cnt      <= '0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV: begin
                    rq <= rq_next;
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= SIGN;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                SIGN: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with MUL_CYCLES=2.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.MUL_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_type      (op_type),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .stall_req    (stall_req),
        .busy         (busy),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the sequencer idle; issues one operation,
    // waits for result_valid and checks latency, result and return to idle.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int lat,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n        = 0;
        op_valid = 1'b1;
        op_type  = op;
        src_a    = a;
        src_b    = b;
        #1;
        checkOutput({tag, "_stall_t0"}, 32'(stall_req), 32'd1);
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (result_valid) break;
            checkOutput({tag, "_stall"}, 32'(stall_req), 32'd1);
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'(lat));
        checkOutput({tag, "_hi"}, hi, exp_hi);
        checkOutput({tag, "_lo"}, lo, exp_lo);
        checkOutput({tag, "_stall_done"}, 32'(stall_req), 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, "_rv_after"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        op_valid = 1'b1;
        op_type  = MD_MULT;
        src_a    = 32'd0;
        src_b    = 32'd0;
        flush    = 1'b0;
        #12;
        checkOutput("rst_stall", 32'(stall_req), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rv", 32'(result_valid), 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);

        applyStimulus("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 3,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
        applyStimulus("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,  32'hFFFF_FFFE, 32'h0000_0001);
        applyStimulus("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        applyStimulus("div_negb",  MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD);
        applyStimulus("divu_7_3",  MD_DIVU,  32'h0000_0007, 32'h0000_0003, 34, 32'h0000_0001, 32'h0000_0002);
        applyStimulus("divu_zero", MD_DIVU,  32'h0000_0007, 32'h0000_0000, 34, 32'h0000_0007, 32'hFFFF_FFFF);
        applyStimulus("div_zero",  MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 34, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        applyStimulus("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);

        // Flush at the 11th divide cycle (iteration 10); hi/lo keep div_ovf result.
        op_valid = 1'b1;
        op_type  = MD_DIV;
        src_a    = 32'd100;
        src_b    = 32'd7;
        repeat (11) @(negedge clk);
        checkOutput("flush_busy_before", 32'(busy), 32'd1);
        flush    = 1'b1;
        op_valid = 1'b0;
        #1;
        checkOutput("flush_rv", 32'(result_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy_after", 32'(busy), 32'd0);
        checkOutput("flush_rv_after", 32'(result_valid), 32'd0);
        checkOutput("flush_hi_kept", hi, 32'h0000_0000);
        checkOutput("flush_lo_kept", lo, 32'h8000_0000);
        applyStimulus("multu_post_flush", MD_MULTU, 32'd5, 32'd6, 3, 32'h0000_0000, 32'h0000_001E);

        // Asynchronous reset in the middle of a divide.
        op_valid = 1'b1;
        op_type  = MD_DIV;
        src_a    = 32'd100;
        src_b    = 32'd7;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_stall", 32'(stall_req), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_rv", 32'(result_valid), 32'd0);
        checkOutput("midrst_hi", hi, 32'd0);
        checkOutput("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        checkOutput("postrst_busy", 32'(busy), 32'd0);
        checkOutput("postrst_rv", 32'(result_valid), 32'd0);
        applyStimulus("mult_post_rst", MD_MULT, 32'd2, 32'd3, 3, 32'h0000_0000, 32'h0000_0006);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
